ctrl_pipe_unit: RTL and testbench

Parametrised MIPS pipeline control unit. It decodes the ID-stage instruction, resolves beq/bne/j in ID, and carries control bits through its own ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards against its own EX-stage state and drives PC/IF-ID stall and flush. It sits beside the datapath pipeline registers and replaces the purely combinational decoder.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/ctrl_decode.sv | 60 ++++++
 rtl/ctrl_pipe_unit.sv | 133 +++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALU function codes, PC-select
// encodings and the per-instruction control bundle carried down the pipe.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_NOPE  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Width of the func field inside the control bundle; the unit's FUNC_W is
  // expected to match it.
  localparam int CTRL_FUNC_W = 6;

  localparam logic [CTRL_FUNC_W-1:0] FUNC_ADDF = 6'b100000;
  localparam logic [CTRL_FUNC_W-1:0] FUNC_NOPF = 6'b000000;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic                   alu_src;
    logic                   reg_dst;
    logic [CTRL_FUNC_W-1:0] func;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic                   mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: control bundle, illegal flag and the
// branch/jump class of the ID-stage instruction.
module ctrl_decode
  import mips_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int FUNC_W = 6,
  parameter int EN_IMM = 1
) (
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [FUNC_W-1:0] func_i,
  output ctrl_t             ctrl_o,
  output logic              illegal_o,
  output logic              is_beq_o,
  output logic              is_bne_o,
  output logic              is_j_o
);

  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    illegal_o = 1'b0;
    is_beq_o  = 1'b0;
    is_bne_o  = 1'b0;
    is_j_o    = 1'b0;
    case (opcode_i)
      OP_W'(OP_LW): begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.func       = FUNC_ADDF;
      end
      OP_W'(OP_SW): begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.func      = FUNC_ADDF;
      end
      OP_W'(OP_RTYPE): begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.func      = CTRL_FUNC_W'(func_i);
      end
      OP_W'(OP_BEQ):  is_beq_o = 1'b1;
      OP_W'(OP_BNE):  is_bne_o = 1'b1;
      OP_W'(OP_J):    is_j_o   = 1'b1;
      OP_W'(OP_NOPE): ;
      OP_W'(OP_ADDI): begin
        if (EN_IMM != 0) begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.func      = FUNC_ADDF;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipeline control unit: ID decode, branch/jump resolution, load-use
// interlock, IF/ID flush sequencing and the EX/MEM/WB control registers.
module ctrl_pipe_unit
  import mips_pkg::*;
#(
  parameter int OP_W          = 6,
  parameter int FUNC_W        = 6,
  parameter int FLUSH_DEPTH   = 1,
  parameter int EN_IMM        = 1,
  parameter int LOADUSE_STALL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opcode_id,
  input  logic [FUNC_W-1:0] func_id,
  input  logic [4:0]        rs_id,
  input  logic [4:0]        rt_id,
  input  logic [4:0]        rd_id,
  input  logic              eq_regs,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        pc_src,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [FUNC_W-1:0] ex_func,
  output logic [4:0]        ex_dest,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              illegal_op
);

  ctrl_t      dec_ctrl;
  logic       dec_illegal, dec_beq, dec_bne, dec_j;
  ctrl_t      id_ex_q, id_ex_d;
  logic [4:0] ex_dest_q, ex_dest_d;
  logic       ex_mem_read_q, ex_mem_write_q, ex_mem_reg_write_q, ex_mem_to_reg_q;
  logic       mem_wb_reg_write_q, mem_wb_to_reg_q;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       illegal_q, illegal_d;
  logic       stall;

  ctrl_decode #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W),
    .EN_IMM (EN_IMM)
  ) u_decode (
    .opcode_i  (opcode_id),
    .func_i    (func_id),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .is_beq_o  (dec_beq),
    .is_bne_o  (dec_bne),
    .is_j_o    (dec_j)
  );

  assign stall = (LOADUSE_STALL != 0) && id_ex_q.mem_read && (ex_dest_q != 5'd0) &&
                 ((ex_dest_q == rs_id) || (ex_dest_q == rt_id));

  // Priority: reset, flush in progress (masks decode), load-use stall, normal issue.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    pc_src      = PC_SRC_SEQ;
    id_ex_d     = CTRL_BUBBLE;
    ex_dest_d   = 5'd0;
    flush_cnt_d = flush_cnt_q;
    illegal_d   = illegal_q;
    if (rst) begin
      ifid_flush  = 1'b1;
      flush_cnt_d = 2'd0;
    end else if (flush_cnt_q != 2'd0) begin
      ifid_flush  = 1'b1;
      flush_cnt_d = flush_cnt_q - 2'd1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      id_ex_d   = dec_ctrl;
      ex_dest_d = dec_ctrl.reg_dst ? rd_id : rt_id;
      illegal_d = illegal_q | dec_illegal;
      if ((dec_beq && eq_regs) || (dec_bne && !eq_regs)) begin
        pc_src      = PC_SRC_BRANCH;
        ifid_flush  = 1'b1;
        flush_cnt_d = 2'(FLUSH_DEPTH - 1);
      end else if (dec_j) begin
        pc_src      = PC_SRC_JUMP;
        ifid_flush  = 1'b1;
        flush_cnt_d = 2'(FLUSH_DEPTH - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q            <= CTRL_BUBBLE;
      ex_dest_q          <= 5'd0;
      ex_mem_read_q      <= 1'b0;
      ex_mem_write_q     <= 1'b0;
      ex_mem_reg_write_q <= 1'b0;
      ex_mem_to_reg_q    <= 1'b0;
      mem_wb_reg_write_q <= 1'b0;
      mem_wb_to_reg_q    <= 1'b0;
      flush_cnt_q        <= 2'd0;
      illegal_q          <= 1'b0;
    end else begin
      id_ex_q            <= id_ex_d;
      ex_dest_q          <= ex_dest_d;
      ex_mem_read_q      <= id_ex_q.mem_read;
      ex_mem_write_q     <= id_ex_q.mem_write;
      ex_mem_reg_write_q <= id_ex_q.reg_write;
      ex_mem_to_reg_q    <= id_ex_q.mem_to_reg;
      mem_wb_reg_write_q <= ex_mem_reg_write_q;
      mem_wb_to_reg_q    <= ex_mem_to_reg_q;
      flush_cnt_q        <= flush_cnt_d;
      illegal_q          <= illegal_d;
    end
  end

  assign ex_alu_src    = id_ex_q.alu_src;
  assign ex_reg_dst    = id_ex_q.reg_dst;
  assign ex_func       = FUNC_W'(id_ex_q.func);
  assign ex_dest       = ex_dest_q;
  assign mem_read      = ex_mem_read_q;
  assign mem_write     = ex_mem_write_q;
  assign wb_reg_write  = mem_wb_reg_write_q;
  assign wb_mem_to_reg = mem_wb_to_reg_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench: two units (FLUSH_DEPTH=1/EN_IMM=0 and FLUSH_DEPTH=3/EN_IMM=1)
// share one instruction stream; a reference model predicts every stage.
module tb_ctrl_pipe_unit;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04;
  localparam logic [5:0] BNE = 6'h05, JMP = 6'h02, NOPE = 6'h01, ADDI = 6'h08;

  typedef struct packed {
    logic       pcw, ifw, flush;
    logic [1:0] src;
    logic       alu_src, reg_dst;
    logic [5:0] func;
    logic [4:0] dest;
    logic       illegal;
    logic       mem_read, mem_write, reg_write, mem_to_reg;
  } obs_t;

  typedef struct {
    int   due;
    obs_t a;
    obs_t b;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [5:0] opcode_id = NOPE, func_id = '0;
  logic [4:0] rs_id = '0, rt_id = '0, rd_id = '0;
  logic       eq_regs = 1'b0;

  logic       pcw_a, ifw_a, flush_a, alu_a, rdst_a, mr_a, mw_a, rw_a, m2r_a, ill_a;
  logic       pcw_b, ifw_b, flush_b, alu_b, rdst_b, mr_b, mw_b, rw_b, m2r_b, ill_b;
  logic [1:0] src_a, src_b;
  logic [5:0] func_a, func_b;
  logic [4:0] dest_a, dest_b;

  ctrl_pipe_unit #(.OP_W(6), .FUNC_W(6), .FLUSH_DEPTH(1), .EN_IMM(0), .LOADUSE_STALL(1)) dut_a (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .func_id(func_id), .rs_id(rs_id),
    .rt_id(rt_id), .rd_id(rd_id), .eq_regs(eq_regs), .pc_write(pcw_a), .ifid_write(ifw_a),
    .ifid_flush(flush_a), .pc_src(src_a), .ex_alu_src(alu_a), .ex_reg_dst(rdst_a),
    .ex_func(func_a), .ex_dest(dest_a), .mem_read(mr_a), .mem_write(mw_a),
    .wb_reg_write(rw_a), .wb_mem_to_reg(m2r_a), .illegal_op(ill_a));

  ctrl_pipe_unit #(.OP_W(6), .FUNC_W(6), .FLUSH_DEPTH(3), .EN_IMM(1), .LOADUSE_STALL(1)) dut_b (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .func_id(func_id), .rs_id(rs_id),
    .rt_id(rt_id), .rd_id(rd_id), .eq_regs(eq_regs), .pc_write(pcw_b), .ifid_write(ifw_b),
    .ifid_flush(flush_b), .pc_src(src_b), .ex_alu_src(alu_b), .ex_reg_dst(rdst_b),
    .ex_func(func_b), .ex_dest(dest_b), .mem_read(mr_b), .mem_write(mw_b),
    .wb_reg_write(rw_b), .wb_mem_to_reg(m2r_b), .illegal_op(ill_b));

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  rec_t combq[$], exq[$], memq[$], wbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state per unit: pending load destination in EX (-1 none),
  // remaining flush slots, and the sticky illegal flag.
  int m_load[2] = '{-1, -1};
  int m_flush[2] = '{0, 0};
  bit m_ill[2] = '{1'b0, 1'b0};

  function automatic obs_t model_step(input int d, input logic r, input logic [5:0] op,
                                      input logic [5:0] f, input logic [4:0] s, t, dd,
                                      input logic e);
    obs_t o;
    int   depth;
    bit   unknown, taken, jump;
    depth = (d == 0) ? 1 : 3;
    o = '0;
    o.pcw = 1'b1;
    o.ifw = 1'b1;
    unknown = 1'b0;
    taken = 1'b0;
    jump = 1'b0;
    if (r) begin
      o.flush = 1'b1;
      m_flush[d] = 0;
      m_load[d] = -1;
      m_ill[d] = 1'b0;
    end else if (m_flush[d] > 0) begin
      o.flush = 1'b1;
      m_flush[d] = m_flush[d] - 1;
      m_load[d] = -1;
    end else if (m_load[d] > 0 && (m_load[d] == int'(s) || m_load[d] == int'(t))) begin
      o.pcw = 1'b0;
      o.ifw = 1'b0;
      m_load[d] = -1;
    end else begin
      case (op)
        LW:   begin o.alu_src = 1; o.mem_to_reg = 1; o.reg_write = 1; o.mem_read = 1; o.func = 6'h20; end
        SW:   begin o.alu_src = 1; o.mem_write = 1; o.func = 6'h20; end
        RT:   begin o.reg_dst = 1; o.reg_write = 1; o.func = f; end
        BEQ:  taken = e;
        BNE:  taken = !e;
        JMP:  jump = 1'b1;
        NOPE: ;
        ADDI: begin
          if (d == 1) begin o.alu_src = 1; o.reg_write = 1; o.func = 6'h20; end
          else unknown = 1'b1;
        end
        default: unknown = 1'b1;
      endcase
      o.dest = o.reg_dst ? dd : t;
      if (taken || jump) begin
        o.src = taken ? 2'b01 : 2'b10;
        o.flush = 1'b1;
        m_flush[d] = depth - 1;
      end
      m_load[d] = (op == LW) ? int'(t) : -1;
      if (unknown) m_ill[d] = 1'b1;
    end
    o.illegal = m_ill[d];
    return o;
  endfunction

  function automatic obs_t get_act(input int d);
    obs_t o;
    if (d == 0)
      o = '{pcw_a, ifw_a, flush_a, src_a, alu_a, rdst_a, func_a, dest_a, ill_a, mr_a, mw_a, rw_a, m2r_a};
    else
      o = '{pcw_b, ifw_b, flush_b, src_b, alu_b, rdst_b, func_b, dest_b, ill_b, mr_b, mw_b, rw_b, m2r_b};
    return o;
  endfunction

  task automatic check(input string nm, input int d, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle each stage presents a value; pop the prediction due now.
  always @(negedge clk) begin
    rec_t r;
    obs_t act, exp;
    while (combq.size() > 0 && combq[0].due <= cyc) begin
      r = combq.pop_front();
      for (int d = 0; d < 2; d++) begin
        act = get_act(d);
        exp = (d == 0) ? r.a : r.b;
        check("due", d, r.due, cyc);
        check("pc_write", d, act.pcw, exp.pcw);
        check("ifid_write", d, act.ifw, exp.ifw);
        check("ifid_flush", d, act.flush, exp.flush);
        check("pc_src", d, act.src, exp.src);
      end
    end
    while (exq.size() > 0 && exq[0].due <= cyc) begin
      r = exq.pop_front();
      for (int d = 0; d < 2; d++) begin
        act = get_act(d);
        exp = (d == 0) ? r.a : r.b;
        check("ex_ctrl", d, {act.alu_src, act.reg_dst, act.func}, {exp.alu_src, exp.reg_dst, exp.func});
        check("ex_dest", d, act.dest, exp.dest);
        check("illegal_op", d, act.illegal, exp.illegal);
      end
    end
    while (memq.size() > 0 && memq[0].due <= cyc) begin
      r = memq.pop_front();
      for (int d = 0; d < 2; d++) begin
        act = get_act(d);
        exp = (d == 0) ? r.a : r.b;
        check("mem_ctrl", d, {act.mem_read, act.mem_write}, {exp.mem_read, exp.mem_write});
      end
    end
    while (wbq.size() > 0 && wbq[0].due <= cyc) begin
      r = wbq.pop_front();
      for (int d = 0; d < 2; d++) begin
        act = get_act(d);
        exp = (d == 0) ? r.a : r.b;
        check("wb_ctrl", d, {act.reg_write, act.mem_to_reg}, {exp.reg_write, exp.mem_to_reg});
      end
    end
  end

  task automatic issue(input logic r, input logic [5:0] op, input logic [5:0] f,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] dd,
                       input logic e);
    rec_t rec;
    @(posedge clk);
    #1;
    rst = r; opcode_id = op; func_id = f; rs_id = s; rt_id = t; rd_id = dd; eq_regs = e;
    if (r) begin
      // A reset edge clears the later stages, so predictions already queued behind it become zero.
      foreach (memq[i]) if (memq[i].due > cyc) begin rec = memq[i]; rec.a = '0; rec.b = '0; memq[i] = rec; end
      foreach (wbq[i]) if (wbq[i].due > cyc) begin rec = wbq[i]; rec.a = '0; rec.b = '0; wbq[i] = rec; end
    end
    rec.a = model_step(0, r, op, f, s, t, dd, e);
    rec.b = model_step(1, r, op, f, s, t, dd, e);
    rec.due = cyc;     combq.push_back(rec);
    rec.due = cyc + 1; exq.push_back(rec);
    rec.due = cyc + 2; memq.push_back(rec);
    rec.due = cyc + 3; wbq.push_back(rec);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, NOPE, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    logic [5:0] op;
    issue(1'b1, NOPE, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    issue(1'b1, NOPE, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    issue(1'b0, RT, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0);
    nops(3);
    // load-use with a real register, then with $0
    issue(1'b0, LW, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
    issue(1'b0, RT, 6'h20, 5'd5, 5'd6, 5'd7, 1'b0);
    issue(1'b0, RT, 6'h20, 5'd5, 5'd6, 5'd7, 1'b0);
    issue(1'b0, LW, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
    issue(1'b0, RT, 6'h20, 5'd0, 5'd6, 5'd7, 1'b0);
    nops(3);
    issue(1'b0, BEQ, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
    nops(3);
    issue(1'b0, BNE, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
    issue(1'b0, JMP, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    issue(1'b0, LW, 6'h00, 5'd1, 5'd9, 5'd0, 1'b0);
    issue(1'b0, RT, 6'h20, 5'd1, 5'd2, 5'd8, 1'b0);
    nops(3);
    // stall and branch together
    issue(1'b0, LW, 6'h00, 5'd1, 5'd4, 5'd0, 1'b0);
    issue(1'b0, BEQ, 6'h00, 5'd4, 5'd2, 5'd0, 1'b1);
    issue(1'b0, BEQ, 6'h00, 5'd4, 5'd2, 5'd0, 1'b1);
    nops(3);
    issue(1'b0, ADDI, 6'h00, 5'd1, 5'd3, 5'd0, 1'b0);
    nops(3);
    issue(1'b0, 6'h3f, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    nops(2);
    // reset in the middle of a jump flush
    issue(1'b0, JMP, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    issue(1'b1, NOPE, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    issue(1'b0, RT, 6'h22, 5'd1, 5'd2, 5'd3, 1'b0);
    nops(3);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1: op = LW;
        2:    op = SW;
        3, 4: op = RT;
        5:    op = BEQ;
        6:    op = BNE;
        7:    op = JMP;
        8:    op = ADDI;
        default: op = 6'($urandom_range(0, 63));
      endcase
      issue(($urandom_range(0, 63) == 0), op, 6'($urandom_range(0, 63)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
    end
    nops(5);
    for (int i = 0; i < 20 && (combq.size() + exq.size() + memq.size() + wbq.size()) > 0; i++)
      @(negedge clk);
    #1;
    n_checks++;
    if ((combq.size() + exq.size() + memq.size() + wbq.size()) != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0",
               combq.size() + exq.size() + memq.size() + wbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
